// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared branch predictor types and defaults
package branch_predictor_pkg;

    localparam int BP_IDX_W = 4;
    localparam int BP_TAG_W = 8;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup and EX resolve bundle for the predictor
interface branch_predictor_if;

    logic [63:0] if_pc;
    logic        pred_taken;
    logic [63:0] pred_target;
    logic        ex_valid;
    logic [63:0] ex_pc;
    logic        ex_is_branch;
    logic        ex_br_taken;
    logic [63:0] ex_target;
    logic        ex_pred_taken;
    logic [63:0] ex_pred_target;
    logic        mispredict;
    logic [63:0] redirect_pc;
    logic [31:0] mispred_cnt;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_is_branch, ex_br_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc, mispred_cnt
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_is_branch, ex_br_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc, mispred_cnt
    );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// rtl/branch_predictor_sat_counter2.sv - 2-bit saturating direction counter
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] next_ctr_o
);

    // Step toward taken/not-taken, holding at the strong ends
    always_comb begin
        next_ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != CTR_ST) next_ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != CTR_SNT) next_ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BHT/BTB with mispredict detection
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = BP_IDX_W,
    parameter int TAG_W = BP_TAG_W
) (
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bp
);

    localparam int N = 1 << IDX_W;

    // Entry storage kept in flops so the fetch read is purely combinational
    logic [N-1:0]     valid_q, valid_d;
    logic [TAG_W-1:0] tag_q [N];
    logic [TAG_W-1:0] tag_d [N];
    logic [63:0]      tgt_q [N];
    logic [63:0]      tgt_d [N];
    logic [1:0]       ctr_q [N];
    logic [1:0]       ctr_d [N];
    logic [31:0]      mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit, actual;
    logic [1:0]       ctr_nxt;

    assign if_idx = bp.if_pc[IDX_W+1:2];
    assign if_tag = bp.if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign ex_idx = bp.ex_pc[IDX_W+1:2];
    assign ex_tag = bp.ex_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign actual = bp.ex_is_branch & bp.ex_br_taken;

    sat_counter2 u_sat_counter2 (
        .ctr_i      (ctr_q[ex_idx]),
        .taken_i    (actual),
        .next_ctr_o (ctr_nxt)
    );

    // Fetch prediction and EX resolution; reads pre-update state, no bypass
    always_comb begin
        bp.pred_taken  = if_hit & ctr_q[if_idx][1];
        bp.pred_target = bp.pred_taken ? tgt_q[if_idx] : bp.if_pc + 64'd4;
        bp.mispredict  = bp.ex_valid &
                         ((actual != bp.ex_pred_taken) |
                          (actual & (bp.ex_pred_target != bp.ex_target)));
        bp.redirect_pc = actual ? bp.ex_target : bp.ex_pc + 64'd4;
        bp.mispred_cnt = mispred_cnt_q;
    end

    // Table update: train on hit, allocate on miss, drop aliased non-branch hits
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        if (bp.ex_valid && bp.ex_is_branch) begin
            if (ex_hit) begin
                ctr_d[ex_idx] = ctr_nxt;
                if (actual) tgt_d[ex_idx] = bp.ex_target;
            end else begin
                valid_d[ex_idx] = 1'b1;
                tag_d[ex_idx]   = ex_tag;
                tgt_d[ex_idx]   = bp.ex_target;
                ctr_d[ex_idx]   = actual ? CTR_WT : CTR_WNT;
            end
        end else if (bp.ex_valid && ex_hit) begin
            valid_d[ex_idx] = 1'b0;
        end
    end

    // Mispredict counter saturates instead of wrapping
    always_comb begin
        mispred_cnt_d = mispred_cnt_q;
        if (bp.mispredict && (mispred_cnt_q != 32'hFFFF_FFFF))
            mispred_cnt_d = mispred_cnt_q + 32'd1;
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= '0;
            mispred_cnt_q <= '0;
            for (int i = 0; i < N; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= CTR_WNT;
            end
        end else begin
            valid_q       <= valid_d;
            tag_q         <= tag_d;
            tgt_q         <= tgt_d;
            ctr_q         <= ctr_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

endmodule
